piso_serializer6: RTL

//  Parallel-in/serial-out serializer, the upstream stage of the 6-bit serial shift register.

---
 rtl/piso_serializer6_if.sv | 28 ++
 rtl/piso_serializer6.sv | 108 ++++++++++
 2 files changed

// File: rtl/piso_serializer6_if.sv
// Handshake and serial-output bundle for piso_serializer6.
// The upstream side (master) offers words; the serializer (slave) emits bits.
//
// Handshake: a word moves on a rising clk edge where din_valid && din_ready
// are both high. din_ready depends only on the serializer's registered state,
// never on din_valid. The upstream holds din stable while din_valid is high
// and the word has not yet been taken.
interface piso_serializer6_if #(
   parameter int WIDTH = 6
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             w;
   logic             w_valid;
   logic             frame_start;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, w, w_valid, frame_start, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, w, w_valid, frame_start, busy
   );
endinterface

// File: rtl/piso_serializer6.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// A word is loaded into the shifter and sent one bit per clk on w. A second
// word offered mid-word waits in the holding buffer. At the last bit, the
// shifter reloads from the buffer, or directly from din, so that consecutive
// words leave with no idle cycle between them.
module piso_serializer6 #(
   parameter int WIDTH     = 6,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   piso_serializer6_if.slave  bus,
   output logic               dbg_state
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shifter, shifter_n;
   logic [WIDTH-1:0] hold, hold_n;
   logic             hold_full, hold_full_n;
   logic [CW-1:0]    cnt, cnt_n;

   logic             accept;
   logic             last;
   logic [WIDTH-1:0] shifted;

   // The buffer is the only thing that can refuse a word.
   assign bus.din_ready = !hold_full;
   assign accept        = bus.din_valid && !hold_full;
   assign last          = (cnt == CW'(WIDTH - 1));

   // The bit on w sits at the outgoing end of the shifter. Each step drops
   // that bit and moves the next one into its place.
   assign shifted = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0}
                              : {1'b0, shifter[WIDTH-1:1]};

   // Outputs are decoded straight from flops. w is forced to 0 when idle.
   assign bus.w           = (state == SHIFT) &&
                            (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);
   assign bus.w_valid     = (state == SHIFT);
   assign bus.frame_start = (state == SHIFT) && (cnt == '0);
   assign bus.busy        = (state == SHIFT) || hold_full;
   assign dbg_state       = (state == SHIFT);

   // Next-state logic. The word boundary has priority: held word, then din, then idle.
   always_comb begin
      state_n     = state;
      shifter_n   = shifter;
      hold_n      = hold;
      hold_full_n = hold_full;
      cnt_n       = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               shifter_n = bus.din;
               cnt_n     = '0;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               cnt_n = '0;
               if (hold_full) begin
                  shifter_n   = hold;
                  hold_full_n = 1'b0;
               end else if (bus.din_valid) begin
                  shifter_n = bus.din;
               end else begin
                  shifter_n = '0;
                  state_n   = IDLE;
               end
            end else begin
               shifter_n = shifted;
               cnt_n     = cnt + CW'(1);
               if (accept) begin
                  hold_n      = bus.din;
                  hold_full_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset drops any partial or held word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shifter   <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         shifter   <= shifter_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         cnt       <= cnt_n;
      end
   end
endmodule
